multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with retire counter and sticky error flags
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrc,
  output logic [2:0]  ALUctr,
  output logic [1:0]  ExtOp,
  output logic [1:0]  NPCsel,
  output logic [3:0]  state,
  output logic [31:0] instr_cnt,
  output logic        illegal,
  output logic        mem_timeout
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC   = 4'd2;
  localparam logic [3:0] S_MEM_RD = 4'd3;
  localparam logic [3:0] S_MEM_WR = 4'd4;
  localparam logic [3:0] S_WB_ALU = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_BRANCH = 4'd7;
  localparam logic [3:0] S_JUMP   = 4'd8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] WAIT_LIMIT = 4'd15;

  logic [3:0]  state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] instr_cnt_q;
  logic        illegal_q, timeout_q;
  logic        retire, set_illegal, set_timeout;

  logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_exec_class, is_jump;

  assign is_rtype      = (opcode == OP_RTYPE);
  assign is_addu       = is_rtype && (func == FN_ADDU);
  assign is_subu       = is_rtype && (func == FN_SUBU);
  assign is_jr         = is_rtype && (func == FN_JR);
  assign is_ori        = (opcode == OP_ORI);
  assign is_lui        = (opcode == OP_LUI);
  assign is_lw         = (opcode == OP_LW);
  assign is_sw         = (opcode == OP_SW);
  assign is_beq        = (opcode == OP_BEQ);
  assign is_j          = (opcode == OP_J);
  assign is_jal        = (opcode == OP_JAL);
  assign is_exec_class = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw;
  assign is_jump       = is_j | is_jal | is_jr;

  // ALU setup held unchanged from EXEC through MEM_RD/MEM_WR/WB_ALU
  logic [2:0] alu_ctr;
  logic       alu_src;
  logic [1:0] ext_op;

  always_comb begin
    alu_ctr = 3'b000;
    alu_src = 1'b0;
    ext_op  = 2'b00;
    if (is_subu) begin
      alu_ctr = 3'b001;
    end else if (is_ori) begin
      alu_ctr = 3'b010;
      alu_src = 1'b1;
    end else if (is_lui) begin
      alu_ctr = 3'b011;
      alu_src = 1'b1;
    end else if (is_lw || is_sw) begin
      alu_src = 1'b1;
      ext_op  = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      wait_q      <= 4'd0;
      instr_cnt_q <= 32'd0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      if (retire) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
      illegal_q   <= illegal_q | set_illegal;
      timeout_q   <= timeout_q | set_timeout;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (is_exec_class) begin
          state_d = S_EXEC;
        end else if (is_beq) begin
          state_d = S_BRANCH;
        end else if (is_jump) begin
          state_d = S_JUMP;
        end else begin
          set_illegal = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_EXEC: begin
        wait_d = 4'd0;
        if (is_lw) begin
          state_d = S_MEM_RD;
        end else if (is_sw) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_WB_ALU;
        end
      end
      S_MEM_RD, S_MEM_WR: begin
        // completion wins over the timeout when both land in the same cycle
        if (mem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
          retire  = (state_q == S_MEM_WR);
        end else if (wait_q == WAIT_LIMIT) begin
          set_timeout = 1'b1;
          state_d     = S_FETCH;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    ALUSrc   = 1'b0;
    ALUctr   = 3'b000;
    ExtOp    = 2'b00;
    NPCsel   = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      S_EXEC: begin
        ALUctr = alu_ctr;
        ALUSrc = alu_src;
        ExtOp  = ext_op;
      end
      S_MEM_RD: begin
        ALUctr  = alu_ctr;
        ALUSrc  = alu_src;
        ExtOp   = ext_op;
        MemRead = 1'b1;
      end
      S_MEM_WR: begin
        ALUctr   = alu_ctr;
        ALUSrc   = alu_src;
        ExtOp    = ext_op;
        MemWrite = 1'b1;
      end
      S_WB_ALU: begin
        ALUctr   = alu_ctr;
        ALUSrc   = alu_src;
        ExtOp    = ext_op;
        RegWrite = 1'b1;
        RegDst   = is_rtype ? 2'b01 : 2'b00;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_BRANCH: begin
        ALUctr = 3'b001;
        NPCsel = 2'b01;
        PCWr   = zero;
      end
      S_JUMP: begin
        PCWr   = 1'b1;
        NPCsel = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      default: ;
    endcase
    if (!reset) begin
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

  assign state       = state_q;
  assign instr_cnt   = instr_cnt_q;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - instruction-level scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC   = 4'd2;
  localparam logic [3:0] S_MEM_RD = 4'd3;
  localparam logic [3:0] S_MEM_WR = 4'd4;
  localparam logic [3:0] S_WB_ALU = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_BRANCH = 4'd7;
  localparam logic [3:0] S_JUMP   = 4'd8;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef struct packed {
    logic       pcwr;
    logic       irwr;
    logic       regwr;
    logic       memwr;
    logic       memrd;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrc;
    logic [2:0] aluctr;
    logic [1:0] extop;
    logic [1:0] npcsel;
  } ctl_t;

  typedef struct packed {
    logic [3:0]  st;
    ctl_t        c;
    logic [31:0] cnt;
    logic        ill;
    logic        to;
  } rec_t;

  logic        clk, reset, zero, mem_ready;
  logic [5:0]  opcode, func;
  logic        PCWr, IRWr, RegWrite, MemWrite, MemRead, ALUSrc;
  logic [1:0]  RegDst, MemtoReg, ExtOp, NPCsel;
  logic [2:0]  ALUctr;
  logic [3:0]  state;
  logic [31:0] instr_cnt;
  logic        illegal, mem_timeout;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .ALUctr(ALUctr), .ExtOp(ExtOp), .NPCsel(NPCsel),
    .state(state), .instr_cnt(instr_cnt), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  rec_t        exp_q[$];
  rec_t        cr;
  logic [31:0] m_cnt = 32'd0;
  logic        m_ill = 1'b0;
  logic        m_to  = 1'b0;
  logic [5:0]  cur_op = 6'd0;
  logic [5:0]  cur_fn = 6'd0;
  logic        cur_z  = 1'b0;
  logic        bg_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Per-instruction ALU setup, straight from the instruction table
  function automatic ctl_t alu_of(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (op)
      OP_R:   c.aluctr = (fn == FN_SUBU) ? 3'b001 : 3'b000;
      OP_ORI: begin c.aluctr = 3'b010; c.alusrc = 1'b1; end
      OP_LUI: begin c.aluctr = 3'b011; c.alusrc = 1'b1; end
      OP_LW, OP_SW: begin c.alusrc = 1'b1; c.extop = 2'b01; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Drive one cycle's inputs just after the edge and queue what the cycle must show
  task automatic cyc(input logic [3:0] st, input ctl_t c, input logic rst_n, input logic rdy);
    rec_t r;
    @(posedge clk);
    #1;
    reset = rst_n; opcode = cur_op; func = cur_fn; zero = cur_z; mem_ready = rdy;
    if (!rst_n) begin
      c.pcwr = 1'b0; c.irwr = 1'b0; c.regwr = 1'b0; c.memwr = 1'b0; c.memrd = 1'b0;
    end
    r.st = st; r.c = c; r.cnt = m_cnt; r.ill = m_ill; r.to = m_to;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cr = exp_q.pop_front();
      chk("state", {28'd0, state}, {28'd0, cr.st});
      chk("controls", {15'd0, PCWr, IRWr, RegWrite, MemWrite, MemRead, RegDst, MemtoReg,
                       ALUSrc, ALUctr, ExtOp, NPCsel}, {15'd0, cr.c});
      chk("instr_cnt", instr_cnt, cr.cnt);
      chk("sticky_flags", {30'd0, illegal, mem_timeout}, {30'd0, cr.ill, cr.to});
    end
  end

  // One full instruction; rdy_at/abort_at index the cycle within the memory state (-1 = never)
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int rdy_at, input int abort_at,
                     input int lit_cnt, input logic lit_ill, input logic lit_to);
    ctl_t a, c;
    logic [3:0] mst;
    bit is_r, is_exec, is_jmp, rdy, done;
    is_r    = (op == OP_R);
    is_exec = (is_r && (fn == FN_ADDU || fn == FN_SUBU)) ||
              op == OP_ORI || op == OP_LUI || op == OP_LW || op == OP_SW;
    is_jmp  = op == OP_J || op == OP_JAL || (is_r && fn == FN_JR);
    cur_op = op; cur_fn = fn; cur_z = z;
    a = alu_of(op, fn);
    c = '0; c.pcwr = 1'b1; c.irwr = 1'b1;
    cyc(S_FETCH, c, 1'b1, bg_ready);
    if (lit_cnt >= 0) begin
      @(negedge clk);
      chk("lit_instr_cnt", instr_cnt, 32'(lit_cnt));
      chk("lit_illegal", {31'd0, illegal}, {31'd0, lit_ill});
      chk("lit_mem_timeout", {31'd0, mem_timeout}, {31'd0, lit_to});
    end
    cyc(S_DECODE, '0, 1'b1, bg_ready);
    if (op == OP_BEQ) begin
      c = '0; c.aluctr = 3'b001; c.npcsel = 2'b01; c.pcwr = z;
      cyc(S_BRANCH, c, 1'b1, bg_ready);
      m_cnt++;
    end else if (is_jmp) begin
      c = '0; c.pcwr = 1'b1;
      c.npcsel = is_r ? 2'b11 : 2'b10;
      if (op == OP_JAL) begin c.regwr = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
      cyc(S_JUMP, c, 1'b1, bg_ready);
      m_cnt++;
    end else if (!is_exec) begin
      m_ill = 1'b1;
    end else begin
      cyc(S_EXEC, a, 1'b1, bg_ready);
      if (op == OP_LW || op == OP_SW) begin
        mst = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        done = 1'b0;
        for (int k = 0; k < 16; k++) begin
          c = a;
          if (op == OP_LW) c.memrd = 1'b1; else c.memwr = 1'b1;
          if (k == abort_at) begin
            cyc(mst, c, 1'b0, 1'b0);
            @(negedge clk);
            chk("abort_memwrite", {31'd0, MemWrite}, 32'd0);
            m_cnt = 32'd0; m_ill = 1'b0; m_to = 1'b0;
            return;
          end
          rdy = (k == rdy_at);
          cyc(mst, c, 1'b1, rdy);
          if (rdy) begin done = 1'b1; break; end
        end
        if (!done) begin
          m_to = 1'b1;
        end else if (op == OP_SW) begin
          m_cnt++;
        end else begin
          c = '0; c.regwr = 1'b1; c.memtoreg = 2'b01;
          cyc(S_WB_MEM, c, 1'b1, bg_ready);
          m_cnt++;
        end
      end else begin
        c = a; c.regwr = 1'b1; c.regdst = is_r ? 2'b01 : 2'b00;
        cyc(S_WB_ALU, c, 1'b1, bg_ready);
        m_cnt++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; opcode = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    cyc(S_FETCH, '0, 1'b0, 1'b0);
    cyc(S_FETCH, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_instr_cnt", instr_cnt, 32'd0);
    chk("reset_irwr", {31'd0, IRWr}, 32'd0);

    bg_ready = 1'b1;
    run(OP_R, FN_ADDU, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("addu_wb_state", {28'd0, state}, 32'd5);
    chk("addu_wb_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("addu_wb_regdst", {30'd0, RegDst}, 32'd1);

    bg_ready = 1'b0;
    run(OP_LW, 6'd0, 1'b0, 3, -1, 1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lw_wbmem_state", {28'd0, state}, 32'd6);
    chk("lw_wbmem_memtoreg", {30'd0, MemtoReg}, 32'd1);

    run(OP_BEQ, 6'd0, 1'b0, -1, -1, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("beq0_pcwr", {31'd0, PCWr}, 32'd0);
    run(OP_BEQ, 6'd0, 1'b1, -1, -1, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("beq1_pcwr", {31'd0, PCWr}, 32'd1);
    chk("beq1_npcsel", {30'd0, NPCsel}, 32'd1);

    run(OP_JAL, 6'd0, 1'b0, -1, -1, 4, 1'b0, 1'b0);
    @(negedge clk);
    chk("jal_regdst", {30'd0, RegDst}, 32'd2);
    chk("jal_memtoreg", {30'd0, MemtoReg}, 32'd2);
    chk("jal_npcsel", {30'd0, NPCsel}, 32'd2);
    run(OP_R, FN_JR, 1'b0, -1, -1, 5, 1'b0, 1'b0);
    @(negedge clk);
    chk("jr_npcsel", {30'd0, NPCsel}, 32'd3);
    chk("jr_regwrite", {31'd0, RegWrite}, 32'd0);

    run(OP_ORI, 6'd0, 1'b0, -1, -1, 6, 1'b0, 1'b0);
    @(negedge clk);
    chk("ori_aluctr", {29'd0, ALUctr}, 32'd2);
    chk("ori_regdst", {30'd0, RegDst}, 32'd0);
    run(OP_LUI, 6'd0, 1'b0, -1, -1, 7, 1'b0, 1'b0);
    run(OP_R, FN_SUBU, 1'b0, -1, -1, 8, 1'b0, 1'b0);
    run(OP_J, 6'd0, 1'b0, -1, -1, 9, 1'b0, 1'b0);
    run(OP_SW, 6'd0, 1'b0, 2, -1, 10, 1'b0, 1'b0);

    run(OP_SW, 6'd0, 1'b0, -1, -1, 11, 1'b0, 1'b0);
    run(OP_SW, 6'd0, 1'b0, 15, -1, 11, 1'b0, 1'b1);
    run(6'b111111, 6'd0, 1'b0, -1, -1, 12, 1'b0, 1'b1);
    run(OP_R, 6'b000001, 1'b0, -1, -1, 12, 1'b1, 1'b1);
    run(OP_SW, 6'd0, 1'b0, -1, 2, 12, 1'b1, 1'b1);
    run(OP_R, FN_ADDU, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    run(OP_ORI, 6'd0, 1'b0, -1, -1, 1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
